usb_pkt_buffer_ctrl: RTL and testbench
======================================

USB_PKT_BUFFER_CTRL -- requirements
Module: usb_pkt_buffer_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, SHALL set buffer depth to 2^ADDR_WIDTH bytes.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of drop_count.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  capture byte valid.
REQ-006 in_data  in  8  capture byte.
REQ-007 in_last  in  1  byte is final byte of packet.
REQ-008 in_abort  in  1  discard the packet currently being written.
REQ-009 in_ready  out  1  tied high after reset; input never back-pressured.
REQ-010 out_valid  out  1  output byte valid.
REQ-011 out_data  out  8  output byte.
REQ-012 out_last  out  1  final byte of packet.
REQ-013 out_ready  in  1  consumer accepts byte.
REQ-014 pkt_count  out  ADDR_WIDTH+1  committed packets not yet fully read.
REQ-015 level  out  ADDR_WIDTH+1  committed bytes not yet consumed.
REQ-016 drop_count  out  CNT_WIDTH  packets dropped, saturating.

Function
REQ-017 Storage SHALL be one bram_dual_port instance, DATA_WIDTH=9: bits 7:0 = byte, bit 8 = last flag, with 1-cycle registered read latency.
REQ-018 Pointers SHALL be ADDR_WIDTH+1 bits wide: wr_ptr (speculative write), commit_ptr, iss_ptr (read issued), rd_ptr (consumed); RAM address = low ADDR_WIDTH bits; wrap is modulo 2^(ADDR_WIDTH+1).
REQ-019 Full SHALL be defined as wr_ptr - rd_ptr == 2^ADDR_WIDTH.
REQ-020 Write FSM states SHALL be W_IDLE, W_PKT, W_DROP.
REQ-021 W_IDLE/W_PKT, in_valid and not full: write {in_last,in_data} at wr_ptr, increment wr_ptr; if in_last, commit_ptr <= wr_ptr+1 and go to W_IDLE, else W_PKT.
REQ-022 in_valid while full: no write, wr_ptr <= commit_ptr, drop_count increments; go to W_DROP, or W_IDLE if in_last on that byte.
REQ-023 W_DROP: bytes discarded; the byte with in_last returns FSM to W_IDLE; drop_count does not increment again.
REQ-024 in_abort in W_PKT: wr_ptr <= commit_ptr, drop_count increments, go to W_IDLE; in_abort SHALL take priority over a same-cycle in_valid; in_abort in W_IDLE or W_DROP SHALL be ignored.
REQ-025 Uncommitted bytes SHALL never be visible at the output.
REQ-026 Read side SHALL hold a 2-entry output skid buffer; a RAM read at iss_ptr SHALL issue when iss_ptr != commit_ptr and (skid occupancy + reads in flight) < 2, or when that sum equals 2 and one entry is accepted this cycle; iss_ptr then increments.
REQ-027 out_valid/out_data/out_last SHALL be driven from the skid head; transfer occurs on out_valid && out_ready; rd_ptr increments on each transfer.
REQ-028 out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-029 Latency: a byte committed at edge N SHALL appear with out_valid at edge N+2 when the skid is empty; with out_ready held high, throughput SHALL be 1 byte/cycle.
REQ-030 pkt_count: +1 on commit, -1 on out_last transfer; unchanged when both occur in the same cycle.
REQ-031 level SHALL equal commit_ptr - rd_ptr.
REQ-032 drop_count SHALL saturate at all-ones.
REQ-033 Packets longer than 2^ADDR_WIDTH bytes SHALL always be dropped via REQ-022.

Reset
REQ-034 rst_n low SHALL immediately clear all pointers, skid buffer, pkt_count, level and drop_count; set out_valid=0, out_last=0, out_data=0 and in_ready=0; and set FSM to W_IDLE.
REQ-035 in_ready SHALL rise on the first clk edge after rst_n deasserts; a packet in progress at reset is lost and is not counted as dropped.
REQ-036 RAM contents SHALL NOT be cleared.

Structure
REQ-037 Package usb_proxy_pkg SHALL hold the write FSM state enum and the RAM word field positions (LAST_BIT=8).
REQ-038 The only sub-module SHALL be bram_dual_port; all control logic stays in this module.

Verification
REQ-039 Single 4-byte packet 0xA1..0xA4, out_ready=1 -> bytes out in order starting 2 cycles after commit, out_last only on 0xA4, pkt_count 1->0, level 4->0.
REQ-040 ADDR_WIDTH=4; write 16-byte packet, out_ready=0; send 3-byte packet -> drop_count=1, level=16, second packet never output.
REQ-041 in_abort after 5 of 8 bytes, then 2-byte packet 0x11,0x22 -> output only 0x11,0x22; drop_count=1.
REQ-042 Random out_ready at 50% duty, 200 random-length packets through ADDR_WIDTH=6 -> output stream equals input stream minus dropped packets; stable data during stalls; no loss across pointer wrap.
REQ-043 rst_n pulsed low mid-packet and mid-read -> outputs zero asynchronously; after release level=0, pkt_count=0, and the next packet passes intact.
REQ-044 drop_count forced to 0xFFFE, then 3 drops -> reads 0xFFFF.

Source files
------------

// File: rtl/usb_proxy_pkg.sv
// Shared definitions for the USB packet buffer: write-side FSM states and
// the layout of one 9-bit RAM word.
package usb_proxy_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PKT  = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    localparam int DATA_BITS  = 8;
    localparam int LAST_BIT   = 8;
    localparam int WORD_WIDTH = 9;

endpackage

// File: rtl/bram_dual_port.sv
// Simple dual-port block RAM: one write port, one read port with a
// registered (1-cycle) read. Contents are never cleared.
module bram_dual_port #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/usb_pkt_buffer_ctrl.sv
// Packet-granular store-and-forward buffer: bytes are written speculatively
// and only become readable once the packet's last byte commits.
module usb_pkt_buffer_ctrl
    import usb_proxy_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    input  logic                  in_abort,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic [ADDR_WIDTH:0]   level,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]        PTR_ONE   = PW'(1);
    localparam logic [PW-1:0]        PTR_DEPTH = PW'(1) << ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    wr_state_t state_reg, state_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] commit_ptr_reg, commit_ptr_next;
    logic [PW-1:0] iss_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic          in_ready_reg;
    logic [CNT_WIDTH-1:0] drop_count_reg;
    logic [PW-1:0] pkt_count_reg;

    logic full;
    logic ram_we;
    logic drop_event;
    logic commit_event;

    logic [WORD_WIDTH-1:0] ram_wdata;
    logic [WORD_WIDTH-1:0] ram_rdata;

    logic [WORD_WIDTH-1:0] skid_mem_reg [2];
    logic                  skid_wr_idx_reg;
    logic                  skid_rd_idx_reg;
    logic [1:0]            skid_cnt_reg;
    logic                  rd_pending_reg;
    logic [1:0]            occ;
    logic                  read_issue;
    logic                  pop;
    logic [WORD_WIDTH-1:0] skid_head;

    assign full      = (wr_ptr_reg - rd_ptr_reg) == PTR_DEPTH;
    assign ram_wdata = {in_last, in_data};

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= W_IDLE;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            in_ready_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            commit_ptr_reg <= commit_ptr_next;
            in_ready_reg   <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        commit_ptr_next = commit_ptr_reg;
        ram_we          = 1'b0;
        drop_event      = 1'b0;
        commit_event    = 1'b0;
        if (in_ready_reg) begin
            case (state_reg)
                W_IDLE, W_PKT: begin
                    // Abort beats a coincident byte; it only matters mid-packet.
                    if (in_abort && (state_reg == W_PKT)) begin
                        wr_ptr_next = commit_ptr_reg;
                        drop_event  = 1'b1;
                        state_next  = W_IDLE;
                    end else if (in_valid) begin
                        if (full) begin
                            wr_ptr_next = commit_ptr_reg;
                            drop_event  = 1'b1;
                            state_next  = in_last ? W_IDLE : W_DROP;
                        end else begin
                            ram_we      = 1'b1;
                            wr_ptr_next = wr_ptr_reg + PTR_ONE;
                            if (in_last) begin
                                commit_ptr_next = wr_ptr_reg + PTR_ONE;
                                commit_event    = 1'b1;
                                state_next      = W_IDLE;
                            end else begin
                                state_next = W_PKT;
                            end
                        end
                    end
                end
                W_DROP: begin
                    if (in_valid && in_last) begin
                        state_next = W_IDLE;
                    end
                end
                default: state_next = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_reg <= '0;
        end else if (drop_event && (drop_count_reg != {CNT_WIDTH{1'b1}})) begin
            drop_count_reg <= drop_count_reg + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    bram_dual_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (WORD_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
        .wr_data (ram_wdata),
        .rd_en   (read_issue),
        .rd_addr (iss_ptr_reg[ADDR_WIDTH-1:0]),
        .rd_data (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read side: issue reads only up to commit_ptr, land them in a
    // 2-entry skid so a full-rate stream survives the RAM read latency.
    // ------------------------------------------------------------------
    assign occ       = skid_cnt_reg + {1'b0, rd_pending_reg};
    assign skid_head = skid_mem_reg[skid_rd_idx_reg];
    assign pop       = (skid_cnt_reg != 2'd0) && out_ready;

    always_comb begin
        read_issue = 1'b0;
        if (iss_ptr_reg != commit_ptr_reg) begin
            if (occ < 2'd2) begin
                read_issue = 1'b1;
            end else if ((occ == 2'd2) && pop) begin
                read_issue = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                skid_mem_reg[i] <= '0;
            end
            skid_wr_idx_reg <= 1'b0;
            skid_rd_idx_reg <= 1'b0;
            skid_cnt_reg    <= 2'd0;
            rd_pending_reg  <= 1'b0;
            iss_ptr_reg     <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            rd_pending_reg <= read_issue;
            if (read_issue) begin
                iss_ptr_reg <= iss_ptr_reg + PTR_ONE;
            end
            // A push always targets the slot behind the head, so the head
            // stays stable while the consumer stalls.
            if (rd_pending_reg) begin
                skid_mem_reg[skid_wr_idx_reg] <= ram_rdata;
                skid_wr_idx_reg               <= ~skid_wr_idx_reg;
            end
            if (pop) begin
                skid_rd_idx_reg <= ~skid_rd_idx_reg;
                rd_ptr_reg      <= rd_ptr_reg + PTR_ONE;
            end
            case ({rd_pending_reg, pop})
                2'b10:   skid_cnt_reg <= skid_cnt_reg + 2'd1;
                2'b01:   skid_cnt_reg <= skid_cnt_reg - 2'd1;
                default: skid_cnt_reg <= skid_cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_reg <= '0;
        end else begin
            case ({commit_event, pop && skid_head[LAST_BIT]})
                2'b10:   pkt_count_reg <= pkt_count_reg + PTR_ONE;
                2'b01:   pkt_count_reg <= pkt_count_reg - PTR_ONE;
                default: pkt_count_reg <= pkt_count_reg;
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = (skid_cnt_reg != 2'd0);
    assign out_data   = skid_head[DATA_BITS-1:0];
    assign out_last   = out_valid & skid_head[LAST_BIT];
    assign pkt_count  = pkt_count_reg;
    assign level      = commit_ptr_reg - rd_ptr_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_usb_pkt_buffer_ctrl.sv
// Scoreboard bench for usb_pkt_buffer_ctrl with a 16-byte buffer, plus a
// narrow-counter twin instance to observe drop_count saturation.
`timescale 1ns/1ps
module tb_usb_pkt_buffer_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int PMASK = (1 << (AW + 1)) - 1;

    typedef struct packed {
        logic       valid;
        logic       abort;
        logic       last;
        logic [7:0] data;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, in_abort, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, out_last;
    logic [7:0]  out_data;
    logic [AW:0] pkt_count, level;
    logic [15:0] drop_count;

    logic        s_in_ready, s_out_valid, s_out_last;
    logic [7:0]  s_out_data;
    logic [AW:0] s_pkt_count, s_level;
    logic [1:0]  s_drop_count;

    stim_t      stim_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] cur_pkt[$];

    int m_wr, m_commit, m_rd, m_pkt, m_drop, m_state;
    int ready_mode;
    int tests_run    = 0;
    int tests_failed = 0;
    bit lat_enable, lat_armed, lat_first, lat_done;
    int lat_cnt;
    bit prev_stall;
    logic [8:0] prev_head;

    always #5 clk = ~clk;

    usb_pkt_buffer_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_abort(in_abort),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .pkt_count(pkt_count), .level(level), .drop_count(drop_count)
    );

    usb_pkt_buffer_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_abort(in_abort),
        .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last), .out_ready(out_ready),
        .pkt_count(s_pkt_count), .level(s_level), .drop_count(s_drop_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_pkt(input int len, input logic [7:0] start, input logic [7:0] step,
                            input bit with_last, input bit rnd);
        stim_t s;
        for (int i = 0; i < len; i++) begin
            s.valid = 1'b1;
            s.abort = 1'b0;
            s.last  = with_last && (i == len - 1);
            s.data  = rnd ? 8'($urandom) : 8'(start + 8'(i) * step);
            stim_q.push_back(s);
        end
    endtask

    task automatic push_abort();
        stim_t s;
        s = '0;
        s.abort = 1'b1;
        stim_q.push_back(s);
    endtask

    task automatic push_idle(input int n);
        stim_t s;
        s = '0;
        for (int i = 0; i < n; i++) stim_q.push_back(s);
    endtask

    task automatic wait_stim(input string tag, input int budget);
        int n = 0;
        while (stim_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_stim_done"}, 32'(stim_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_drained"}, 32'(stim_q.size() + exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Drive, model and monitor all happen here, once per negedge, in a
    // fixed order so the model sees the same edge ordering as the DUT.
    always @(negedge clk) begin : drive_mon
        stim_t s;
        logic [8:0] e;
        if (!rst_n) begin
            m_wr = 0; m_commit = 0; m_rd = 0; m_pkt = 0; m_drop = 0; m_state = 0;
            exp_q.delete();
            cur_pkt.delete();
            prev_stall = 1'b0;
            lat_armed  = 1'b0;
            in_valid = 1'b0; in_abort = 1'b0; in_last = 1'b0; in_data = 8'h00;
            out_ready = 1'b0;
        end else begin
            check_eq("level", 32'(level), 32'((m_commit - m_rd) & PMASK));
            check_eq("pkt_count", 32'(pkt_count), 32'(m_pkt & PMASK));
            check_eq("drop_count", 32'(drop_count), 32'(m_drop & 16'hFFFF));
            check_eq("sat_drop_count", 32'(s_drop_count), 32'((m_drop > 3) ? 3 : m_drop));
            if (prev_stall) begin
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_data", 32'({out_last, out_data}), 32'(prev_head));
            end
            if (lat_armed) begin
                lat_cnt++;
                if (lat_first && lat_cnt < 3) check_eq("lat_early_valid", 32'(out_valid), 32'd0);
            end

            if (in_ready && stim_q.size() != 0) s = stim_q.pop_front();
            else s = '0;
            in_valid = s.valid;
            in_abort = s.abort;
            in_last  = s.last;
            in_data  = s.data;
            if (in_ready) begin
                if (s.abort && m_state == 1) begin
                    m_wr = m_commit; cur_pkt.delete(); m_drop++; m_state = 0;
                end else if (s.valid) begin
                    if (m_state == 2) begin
                        if (s.last) m_state = 0;
                    end else if (m_wr - m_rd == DEPTH) begin
                        m_wr = m_commit; cur_pkt.delete(); m_drop++;
                        m_state = s.last ? 0 : 2;
                    end else begin
                        cur_pkt.push_back({s.last, s.data});
                        m_wr++;
                        if (s.last) begin
                            foreach (cur_pkt[i]) exp_q.push_back(cur_pkt[i]);
                            cur_pkt.delete();
                            m_commit = m_wr;
                            m_pkt++;
                            m_state = 0;
                            if (lat_enable) begin
                                lat_armed = 1'b1; lat_first = 1'b1; lat_cnt = 0;
                            end
                        end else begin
                            m_state = 1;
                        end
                    end
                end
            end

            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                check_eq("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("out_byte", 32'({out_last, out_data}), 32'(e));
                    m_rd++;
                    if (e[8]) m_pkt--;
                    if (lat_armed) begin
                        if (lat_first) begin
                            check_eq("lat_first_byte", 32'(lat_cnt), 32'd3);
                            lat_first = 1'b0;
                        end
                        if (e[8]) begin
                            check_eq("lat_last_byte", 32'(lat_cnt), 32'd6);
                            lat_armed = 1'b0;
                            lat_done  = 1'b1;
                        end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_head  = {out_last, out_data};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, n;
        rst_n = 1'b0;
        in_valid = 1'b0; in_abort = 1'b0; in_last = 1'b0; in_data = 8'h00;
        out_ready = 1'b0;
        ready_mode = 0;
        lat_enable = 1'b0; lat_done = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_drop", 32'(drop_count), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check_eq("in_ready_rise", 32'(in_ready), 32'd1);

        // Single 4-byte packet, latency and full-rate drain
        ready_mode = 1;
        lat_enable = 1'b1;
        push_pkt(4, 8'hA1, 8'h01, 1'b1, 1'b0);
        wait_drain("basic", 100);
        lat_enable = 1'b0;
        check_eq("basic_lat_seen", 32'(lat_done), 32'd1);
        check_eq("basic_pkt_count", 32'(pkt_count), 32'd0);
        check_eq("basic_level", 32'(level), 32'd0);

        // Fill the buffer exactly, then a packet that must be dropped
        ready_mode = 0;
        push_pkt(16, 8'h30, 8'h01, 1'b1, 1'b0);
        push_pkt(3, 8'h60, 8'h01, 1'b1, 1'b0);
        wait_stim("full", 100);
        check_eq("full_drop_count", 32'(drop_count), 32'd1);
        check_eq("full_level", 32'(level), 32'd16);
        check_eq("full_pkt_count", 32'(pkt_count), 32'd1);
        ready_mode = 2;
        wait_drain("full", 500);

        // Idle abort ignored, mid-packet abort, abort beating a valid byte
        ready_mode = 1;
        push_abort();
        push_pkt(5, 8'h50, 8'h01, 1'b0, 1'b0);
        push_abort();
        push_pkt(2, 8'h11, 8'h11, 1'b1, 1'b0);
        push_pkt(3, 8'h70, 8'h01, 1'b0, 1'b0);
        stim_q.push_back('{valid: 1'b1, abort: 1'b1, last: 1'b0, data: 8'h7F});
        push_pkt(1, 8'h99, 8'h01, 1'b1, 1'b0);
        wait_drain("abort", 200);
        check_eq("abort_drop_count", 32'(drop_count), 32'd3);

        // Random lengths, gaps, aborts and 50% consumer duty across many wraps
        ready_mode = 2;
        for (int p = 0; p < 200; p++) begin
            len = int'($urandom_range(1, 20));
            if ($urandom_range(0, 15) == 0) begin
                push_pkt(len, 8'h00, 8'h00, 1'b0, 1'b1);
                push_abort();
            end else begin
                push_pkt(len, 8'h00, 8'h00, 1'b1, 1'b1);
            end
            push_idle(int'($urandom_range(0, 3)));
        end
        wait_drain("random", 30000);
        check_eq("random_level", 32'(level), 32'd0);
        check_eq("random_pkt_count", 32'(pkt_count), 32'd0);

        // Asynchronous reset mid-packet and mid-read
        ready_mode = 2;
        push_pkt(6, 8'h80, 8'h01, 1'b1, 1'b0);
        push_pkt(10, 8'h90, 8'h01, 1'b0, 1'b0);
        n = 0;
        while (stim_q.size() > 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        stim_q.delete();
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_out_data", 32'(out_data), 32'd0);
        check_eq("arst_out_last", 32'(out_last), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd0);
        check_eq("arst_level", 32'(level), 32'd0);
        check_eq("arst_pkt_count", 32'(pkt_count), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arst_in_ready_rise", 32'(in_ready), 32'd1);
        check_eq("arst_drop", 32'(drop_count), 32'd0);
        ready_mode = 1;
        push_pkt(5, 8'hC0, 8'h03, 1'b1, 1'b0);
        wait_drain("post_reset", 100);
        check_eq("post_reset_level", 32'(level), 32'd0);

        // Four drops: wide counter counts, narrow counter saturates
        for (int k = 0; k < 4; k++) begin
            push_pkt(2, 8'hE0, 8'h01, 1'b0, 1'b0);
            push_abort();
        end
        wait_stim("sat", 100);
        check_eq("sat_wide", 32'(drop_count), 32'd4);
        check_eq("sat_narrow", 32'(s_drop_count), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
